// File: rtl/vx_gbar_unit_pkg.sv
// Shared types and width helpers for the global barrier unit and its
// arbiter-side clients.
package vx_gbar_unit_pkg;

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int calc_log2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_FIELD_W = 8;

    // One barrier-arrive request; fields are wide enough for any supported
    // configuration and are truncated to the instance widths at the port.
    typedef struct packed {
        logic [GBAR_FIELD_W-1:0] id;
        logic [GBAR_FIELD_W-1:0] size_m1;
        logic [GBAR_FIELD_W-1:0] core_id;
    } gbar_req_t;

endpackage

// File: rtl/vx_gbar_unit_if.sv
// Arrive-request / release-broadcast bundle between a socket-level gbar
// arbiter (master) and the global barrier unit (slave).
interface vx_gbar_unit_if
    import vx_gbar_unit_pkg::*;
#(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4
);
    localparam int NB_WIDTH = calc_log2(NUM_BARRIERS);
    localparam int NC_WIDTH = calc_log2(NUM_CORES);

    logic                req_valid;
    logic [NB_WIDTH-1:0] req_id;
    logic [NC_WIDTH-1:0] req_size_m1;
    logic [NC_WIDTH-1:0] req_core_id;
    logic                req_ready;
    logic                rsp_valid;
    logic [NB_WIDTH-1:0] rsp_id;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id
    );

endinterface

// File: rtl/vx_gbar_unit_popcount.sv
// Combinational population count of an N-bit vector.
module vx_gbar_unit_popcount #(
    parameter int N = 4,
    parameter int W = $clog2(N) + 1
) (
    input  logic [N-1:0] in_bits,
    output logic [W-1:0] count
);

    // Ripple sum of set bits.
    always_comb begin
        count = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            count = count + {{(W-1){1'b0}}, in_bits[i]};
        end
    end

endmodule

// File: rtl/vx_gbar_unit.sv
// Global barrier unit: tracks per-slot arrival masks and broadcasts a
// one-cycle release once the requested number of distinct cores has arrived.
module vx_gbar_unit
    import vx_gbar_unit_pkg::*;
#(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    vx_gbar_unit_if.slave gbar,
    output logic        dup_err,
    output logic [31:0] release_count,
    output logic        busy
);

    localparam int NB_WIDTH  = calc_log2(NUM_BARRIERS);
    localparam int NC_WIDTH  = calc_log2(NUM_CORES);
    localparam int CNT_WIDTH = NC_WIDTH + 1;
    localparam logic [NUM_CORES-1:0] CORE_ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

    logic [NUM_CORES-1:0] mask_r [NUM_BARRIERS];
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [NB_WIDTH-1:0]  rsp_id_r;
    logic                 dup_err_r;
    logic [31:0]          release_count_r;
    logic                 busy_r;

    logic                 fire_s;
    logic [NUM_CORES-1:0] cur_mask_s;
    logic [NUM_CORES-1:0] core_bit_s;
    logic [NUM_CORES-1:0] next_mask_s;
    logic [CNT_WIDTH-1:0] arrived_s;
    logic [CNT_WIDTH-1:0] target_s;
    logic                 dup_s;
    logic                 release_s;
    logic                 any_arrived_s;

    vx_gbar_unit_popcount #(
        .N (NUM_CORES),
        .W (CNT_WIDTH)
    ) u_popcount (
        .in_bits (next_mask_s),
        .count   (arrived_s)
    );

    // Arrival decode; the threshold always comes from the current request.
    always_comb begin
        fire_s        = gbar.req_valid & req_ready_r;
        cur_mask_s    = mask_r[gbar.req_id];
        core_bit_s    = CORE_ONE << gbar.req_core_id;
        next_mask_s   = cur_mask_s | core_bit_s;
        dup_s         = fire_s & (|(cur_mask_s & core_bit_s));
        target_s      = {1'b0, gbar.req_size_m1} + {{NC_WIDTH{1'b0}}, 1'b1};
        release_s     = fire_s & ~dup_s & (arrived_s == target_s);
        any_arrived_s = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            any_arrived_s = any_arrived_s | (|mask_r[b]);
        end
    end

    // Barrier state, release pulse and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_r[b] <= {NUM_CORES{1'b0}};
            end
            req_ready_r     <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_id_r        <= {NB_WIDTH{1'b0}};
            dup_err_r       <= 1'b0;
            release_count_r <= 32'd0;
            busy_r          <= 1'b0;
        end else begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= release_s;
            busy_r      <= any_arrived_s;
            if (release_s) begin
                rsp_id_r        <= gbar.req_id;
                release_count_r <= release_count_r + 32'd1;
            end
            if (dup_s) begin
                dup_err_r <= 1'b1;
            end
            // A release clears the slot so the next instance starts empty.
            if (fire_s && !dup_s) begin
                mask_r[gbar.req_id] <= release_s ? {NUM_CORES{1'b0}} : next_mask_s;
            end
        end
    end

    assign gbar.req_ready = req_ready_r;
    assign gbar.rsp_valid = rsp_valid_r;
    assign gbar.rsp_id    = rsp_id_r;
    assign dup_err        = dup_err_r;
    assign release_count  = release_count_r;
    assign busy           = busy_r;

endmodule
